wavelet_accelerator_sequencer: RTL and testbench

WAVELET_ACCELERATOR_SEQUENCER -- requirements
Module: wavelet_accelerator_sequencer

---
 rtl/wavelet_accelerator_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_wavelet_accelerator_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wavelet_accelerator_sequencer.sv
// wavelet_accelerator_sequencer
//
// Control sequencer for a multi-level discrete wavelet transform engine.
// It loads filter coefficients on request, then streams sample reads
// into the datapath level by level, issuing a downsampled (odd-index)
// result write PIPE_LAT cycles after each odd read. It signals completion
// to the host.
//
// Parameters:
//   ADDR_WIDTH - sample address width
//   PIPE_LAT   - cycles from src_rd_en to datapath result valid (1..7)
//
// Ports:
//   clk, rst                 - clock (rising edge), synchronous active-low reset
//   core_init / core_go      - host requests: load coefficients / run decomposition
//   core_r_addr_rst          - host read-pointer reset (no effect on sequencing)
//   core_inputs_len          - length code: 64 << code samples
//   core_dec_level           - number of decomposition levels minus one
//   core_filter_size         - number of coefficients to load
//   dp_ready                 - datapath accepts a sample this cycle
//   core_clear_init/_go      - one-cycle completion pulses
//   core_r_data_available    - results readable (DONE state)
//   coef_load, coef_idx      - coefficient write strobe and index
//   src_rd_en, src_addr      - sample read strobe and address
//   dst_wr_en, dst_addr      - result write strobe and address
//   level                    - current decomposition level
//   busy                     - high in COEF, RUN, DRAIN, NEXT
//   cycle_count              - busy-cycle counter
//
// Optional feature: define WAVELET_SEQ_CYCLE_CNT_EN to build the busy-cycle
// counter; without it cycle_count is tied to zero.

module wavelet_accelerator_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int PIPE_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_init,
  input  logic                  core_go,
  input  logic                  core_r_addr_rst,
  input  logic [1:0]            core_inputs_len,
  input  logic [1:0]            core_dec_level,
  input  logic [4:0]            core_filter_size,
  input  logic                  dp_ready,
  output logic                  core_clear_init,
  output logic                  core_clear_go,
  output logic                  core_r_data_available,
  output logic                  coef_load,
  output logic [4:0]            coef_idx,
  output logic                  src_rd_en,
  output logic [ADDR_WIDTH-1:0] src_addr,
  output logic                  dst_wr_en,
  output logic [ADDR_WIDTH-1:0] dst_addr,
  output logic [1:0]            level,
  output logic                  busy,
  output logic [31:0]           cycle_count
);

  // One extra bit so the read counter can represent a full-length level.
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COEF  = 3'd1,
    ARMED = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    NEXT  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            coef_cnt;
  logic [4:0]            fs_q;
  logic [1:0]            len_q;
  logic [1:0]            dec_q;
  logic [1:0]            level_q;
  logic [CW-1:0]         rd_cnt;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [PIPE_LAT-1:0]   pipe;

  logic [CW-1:0]         n_total;
  logic [CW-1:0]         n_level;
  logic [CW-1:0]         last_rd;
  logic [CW-1:0]         last_wr;
  logic                  last_write_now;
  logic                  start_coef;
  logic                  start_run;
  logic                  next_level;

  // The host read-pointer reset belongs to the result buffer, not here.
  logic unused_addr_rst;
  assign unused_addr_rst = core_r_addr_rst;

  // Samples in the current level: full length halves at each level.
  assign n_total = CW'(64) << len_q;
  assign n_level = n_total >> level_q;
  assign last_rd = n_level - CW'(1);
  assign last_wr = (n_level >> 1) - CW'(1);

  // Delay line tail is the write strobe; it only ever carries odd reads.
  assign dst_wr_en      = pipe[PIPE_LAT-1];
  assign dst_addr       = wr_cnt;
  assign last_write_now = dst_wr_en && ({1'b0, wr_cnt} == last_wr);

  assign level                 = level_q;
  assign busy                  = (state_q == COEF) || (state_q == RUN) ||
                                 (state_q == DRAIN) || (state_q == NEXT);
  assign core_r_data_available = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    coef_load       = 1'b0;
    coef_idx        = '0;
    core_clear_init = 1'b0;
    core_clear_go   = 1'b0;
    src_rd_en       = 1'b0;
    src_addr        = '0;
    start_coef      = 1'b0;
    start_run       = 1'b0;
    next_level      = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_init) begin
          state_d    = COEF;
          start_coef = 1'b1;
        end
      end
      ARMED, DONE: begin
        // A coefficient reload takes priority over a run request.
        if (core_init) begin
          state_d    = COEF;
          start_coef = 1'b1;
        end else if (core_go) begin
          state_d   = RUN;
          start_run = 1'b1;
        end
      end
      COEF: begin
        // After the final index, one extra cycle carries the done pulse.
        if (coef_cnt < fs_q) begin
          coef_load = 1'b1;
          coef_idx  = coef_cnt;
        end else begin
          core_clear_init = 1'b1;
          state_d         = ARMED;
        end
      end
      RUN: begin
        src_rd_en = dp_ready;
        src_addr  = rd_cnt[ADDR_WIDTH-1:0];
        if (dp_ready && (rd_cnt == last_rd)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_write_now) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (level_q == dec_q) begin
          core_clear_go = 1'b1;
          state_d       = DONE;
        end else begin
          next_level = 1'b1;
          state_d    = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      coef_cnt <= '0;
      fs_q     <= '0;
      len_q    <= '0;
      dec_q    <= '0;
      level_q  <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
    end else begin
      if (start_coef) begin
        coef_cnt <= '0;
        fs_q     <= core_filter_size;
      end else if (coef_load) begin
        coef_cnt <= coef_cnt + 5'd1;
      end

      // Configuration is captured only at run start and held until DONE.
      if (start_run) begin
        len_q   <= core_inputs_len;
        dec_q   <= core_dec_level;
        level_q <= '0;
        rd_cnt  <= '0;
        wr_cnt  <= '0;
      end else if (next_level) begin
        level_q <= level_q + 2'd1;
        rd_cnt  <= '0;
        wr_cnt  <= '0;
      end else begin
        if (src_rd_en) begin
          rd_cnt <= rd_cnt + CW'(1);
        end
        if (dst_wr_en) begin
          wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Odd-index reads enter the delay line so that only every second
  // sample produces a result write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= src_rd_en & rd_cnt[0];
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

`ifdef WAVELET_SEQ_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_q <= '0;
    end else if (start_run) begin
      cyc_q <= '0;
    end else if (busy && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycle_count = cyc_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_wavelet_accelerator_sequencer.sv
// Directed testbench for wavelet_accelerator_sequencer.
// A negedge monitor logs reads, writes and pulses; each scenario task
// drives stimulus and compares against hand-derived expectations.

module tb_wavelet_accelerator_sequencer;

  localparam int AW = 10;
  localparam int PL = 2;

  logic          clk;
  logic          rst;
  logic          core_init;
  logic          core_go;
  logic          core_r_addr_rst;
  logic [1:0]    core_inputs_len;
  logic [1:0]    core_dec_level;
  logic [4:0]    core_filter_size;
  logic          dp_ready;
  logic          core_clear_init;
  logic          core_clear_go;
  logic          core_r_data_available;
  logic          coef_load;
  logic [4:0]    coef_idx;
  logic          src_rd_en;
  logic [AW-1:0] src_addr;
  logic          dst_wr_en;
  logic [AW-1:0] dst_addr;
  logic [1:0]    level;
  logic          busy;
  logic [31:0]   cycle_count;

  int tests_run;
  int tests_failed;

  int cyc;
  int rd_addr_q[$];
  int rd_lvl_q[$];
  int rd_cyc_q[$];
  int wr_addr_q[$];
  int wr_lvl_q[$];
  int wr_cyc_q[$];
  int clear_go_cnt;
  int clear_init_cnt;
  int rd_no_ready_cnt;

  wavelet_accelerator_sequencer #(
    .ADDR_WIDTH(AW),
    .PIPE_LAT  (PL)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .core_init            (core_init),
    .core_go              (core_go),
    .core_r_addr_rst      (core_r_addr_rst),
    .core_inputs_len      (core_inputs_len),
    .core_dec_level       (core_dec_level),
    .core_filter_size     (core_filter_size),
    .dp_ready             (dp_ready),
    .core_clear_init      (core_clear_init),
    .core_clear_go        (core_clear_go),
    .core_r_data_available(core_r_data_available),
    .coef_load            (coef_load),
    .coef_idx             (coef_idx),
    .src_rd_en            (src_rd_en),
    .src_addr             (src_addr),
    .dst_wr_en            (dst_wr_en),
    .dst_addr             (dst_addr),
    .level                (level),
    .busy                 (busy),
    .cycle_count          (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (src_rd_en) begin
      rd_addr_q.push_back(int'(src_addr));
      rd_lvl_q.push_back(int'(level));
      rd_cyc_q.push_back(cyc);
      if (!dp_ready) rd_no_ready_cnt = rd_no_ready_cnt + 1;
    end
    if (dst_wr_en) begin
      wr_addr_q.push_back(int'(dst_addr));
      wr_lvl_q.push_back(int'(level));
      wr_cyc_q.push_back(cyc);
    end
    if (core_clear_go)   clear_go_cnt   = clear_go_cnt + 1;
    if (core_clear_init) clear_init_cnt = clear_init_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_addr_q.delete();
    rd_lvl_q.delete();
    rd_cyc_q.delete();
    wr_addr_q.delete();
    wr_lvl_q.delete();
    wr_cyc_q.delete();
    clear_go_cnt    = 0;
    clear_init_cnt  = 0;
    rd_no_ready_cnt = 0;
  endtask

  task automatic test_reset();
    logic [65:0] obs;
    rst = 1'b0;
    core_init = 1'b0;
    core_go = 1'b0;
    core_r_addr_rst = 1'b0;
    core_inputs_len = 2'd0;
    core_dec_level = 2'd0;
    core_filter_size = 5'd0;
    dp_ready = 1'b0;
    repeat (3) tick();
    obs = {busy, src_rd_en, dst_wr_en, coef_load, core_clear_init, core_clear_go,
           core_r_data_available, level, src_addr, dst_addr, coef_idx, cycle_count};
    tests_run++;
    if (obs !== 66'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0", obs);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_go_idle();
    clear_logs();
    dp_ready = 1'b1;
    core_go = 1'b1;
    tick();
    core_go = 1'b0;
    repeat (5) tick();
    tests_run++;
    if (rd_addr_q.size() != 0 || clear_go_cnt != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL go_in_idle: reads=%0d clear_go=%0d busy=%b, expected 0/0/0",
               rd_addr_q.size(), clear_go_cnt, busy);
    end
  endtask

  task automatic test_coef(input int fs);
    int bad;
    clear_logs();
    core_filter_size = fs[4:0];
    core_init = 1'b1;
    tick();
    core_init = 1'b0;
    bad = 0;
    for (int i = 0; i < fs; i++) begin
      if (coef_load !== 1'b1 || coef_idx !== i[4:0] || core_clear_init !== 1'b0 ||
          busy !== 1'b1)
        bad++;
      tick();
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL coef_seq fs=%0d: %0d bad cycles, expected 0", fs, bad);
    end
    tests_run++;
    if (core_clear_init !== 1'b1 || coef_load !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL coef_done_pulse fs=%0d: clear_init=%b coef_load=%b, expected 1/0",
               fs, core_clear_init, coef_load);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || core_clear_init !== 1'b0 || clear_init_cnt != 1 ||
        core_r_data_available !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL coef_armed fs=%0d: busy=%b pulse=%b pulses=%0d avail=%b, expected 0/0/1/0",
               fs, busy, core_clear_init, clear_init_cnt, core_r_data_available);
    end
  endtask

  task automatic test_decomposition(input int len, input int dec, input bit toggle);
    int n;
    int ri;
    int wi;
    int bad;
    int base;
    int nl;
    int exp_cc;
    clear_logs();
    core_inputs_len = len[1:0];
    core_dec_level  = dec[1:0];
    dp_ready = 1'b1;
    core_go = 1'b1;
    tick();
    core_go = 1'b0;
    core_inputs_len = ~len[1:0];
    core_dec_level  = ~dec[1:0];
    for (int t = 0; t < 5000 && clear_go_cnt == 0; t++) begin
      if (toggle) dp_ready = ~dp_ready;
      tick();
    end
    dp_ready = 1'b1;
    tests_run++;
    if (clear_go_cnt == 0) begin
      tests_failed++;
      $display("[TB] FAIL run_timeout len=%0d dec=%0d: clear_go never seen", len, dec);
    end
    tests_run++;
    if (core_r_data_available !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL run_done_state: avail=%b busy=%b, expected 1/0",
               core_r_data_available, busy);
    end
    n = 64 << len;
    if (!toggle) begin
      exp_cc = 0;
      for (int l = 0; l <= dec; l++) exp_cc += (n >> l) + PL + 1;
`ifndef WAVELET_SEQ_CYCLE_CNT_EN
      exp_cc = 0;
`endif
      tests_run++;
      if (cycle_count !== exp_cc) begin
        tests_failed++;
        $display("[TB] FAIL cycle_count: got %0d, expected %0d", cycle_count, exp_cc);
      end
    end
    repeat (3) tick();
    tests_run++;
    if (clear_go_cnt != 1 || core_r_data_available !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL clear_go_count: got %0d avail=%b, expected 1/1",
               clear_go_cnt, core_r_data_available);
    end
    ri = 0;
    wi = 0;
    for (int l = 0; l <= dec; l++) begin
      nl = n >> l;
      base = ri;
      bad = 0;
      for (int a = 0; a < nl; a++) begin
        if (ri >= rd_addr_q.size()) bad++;
        else if (rd_addr_q[ri] != a || rd_lvl_q[ri] != l) bad++;
        ri++;
      end
      tests_run++;
      if (bad != 0) begin
        tests_failed++;
        $display("[TB] FAIL read_seq len=%0d level=%0d: %0d bad reads, expected 0", len, l, bad);
      end
      bad = 0;
      for (int i = 0; i < nl / 2; i++) begin
        if (wi >= wr_addr_q.size() || base + 2 * i + 1 >= rd_cyc_q.size()) bad++;
        else if (wr_addr_q[wi] != i || wr_lvl_q[wi] != l ||
                 wr_cyc_q[wi] != rd_cyc_q[base + 2 * i + 1] + PL) bad++;
        wi++;
      end
      tests_run++;
      if (bad != 0) begin
        tests_failed++;
        $display("[TB] FAIL write_seq len=%0d level=%0d: %0d bad writes, expected 0", len, l, bad);
      end
    end
    tests_run++;
    if (rd_addr_q.size() != ri || wr_addr_q.size() != wi || rd_no_ready_cnt != 0) begin
      tests_failed++;
      $display("[TB] FAIL totals: reads=%0d writes=%0d unready_reads=%0d, expected %0d/%0d/0",
               rd_addr_q.size(), wr_addr_q.size(), rd_no_ready_cnt, ri, wi);
    end
  endtask

  task automatic test_init_go_done();
    clear_logs();
    core_filter_size = 5'd4;
    core_init = 1'b1;
    core_go = 1'b1;
    tick();
    core_init = 1'b0;
    core_go = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || core_r_data_available !== 1'b0 || coef_load !== 1'b1 ||
        coef_idx !== 5'd0 || src_rd_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL init_go_in_done: busy=%b avail=%b load=%b idx=%0d rd=%b, expected 1/0/1/0/0",
               busy, core_r_data_available, coef_load, coef_idx, src_rd_en);
    end
    repeat (8) tick();
    tests_run++;
    if (rd_addr_q.size() != 0 || clear_init_cnt != 1 || busy !== 1'b0 ||
        core_r_data_available !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL init_go_armed: reads=%0d pulses=%0d busy=%b avail=%b, expected 0/1/0/0",
               rd_addr_q.size(), clear_init_cnt, busy, core_r_data_available);
    end
  endtask

  task automatic test_reset_midrun();
    bit found;
    logic [65:0] obs;
    int wr_snap;
    int rd_snap;
    clear_logs();
    core_inputs_len = 2'd0;
    core_dec_level = 2'd0;
    dp_ready = 1'b1;
    core_go = 1'b1;
    tick();
    core_go = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 300 && !found; t++) begin
      @(negedge clk);
      if (src_rd_en === 1'b1 && src_addr === 10'd20) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("[TB] FAIL midrun_read20: read of address 20 not seen");
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    obs = {busy, src_rd_en, dst_wr_en, coef_load, core_clear_init, core_clear_go,
           core_r_data_available, level, src_addr, dst_addr, coef_idx, cycle_count};
    tests_run++;
    if (obs !== 66'd0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_reset_outputs: got %h, expected 0", obs);
    end
    wr_snap = wr_addr_q.size();
    tick();
    rst = 1'b1;
    repeat (10) tick();
    tests_run++;
    if (wr_addr_q.size() != wr_snap) begin
      tests_failed++;
      $display("[TB] FAIL midrun_no_writes: got %0d writes after reset, expected 0",
               wr_addr_q.size() - wr_snap);
    end
    rd_snap = rd_addr_q.size();
    core_go = 1'b1;
    tick();
    core_go = 1'b0;
    repeat (10) tick();
    tests_run++;
    if (rd_addr_q.size() != rd_snap || clear_go_cnt != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_go_ignored: reads=%0d clear_go=%0d busy=%b, expected 0/0/0",
               rd_addr_q.size() - rd_snap, clear_go_cnt, busy);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    cyc = 0;
    clear_go_cnt = 0;
    clear_init_cnt = 0;
    rd_no_ready_cnt = 0;
    test_reset();
    test_go_idle();
    test_coef(8);
    test_decomposition(0, 0, 1'b0);
    test_decomposition(0, 3, 1'b0);
    test_decomposition(0, 1, 1'b1);
    test_coef(0);
    test_decomposition(3, 0, 1'b0);
    test_init_go_done();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
